// File: rtl/tdm_mux_4_1.sv
// 4:1 TDM gather mux: four valid/ready producers into one tagged stream. Optional TDM_STRICT_SLOT_EN selects fixed slots.
// Latency: 1 clk from input capture to output at the earliest. Backpressure: output holds while stalled; in_ready = ~full only.
module tdm_mux_4_1 #(
    parameter int DW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4*DW-1:0] in_data,
    input  logic [3:0]      in_valid,
    output logic [3:0]      in_ready,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_sel,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [DW-1:0] buf_dat [4];
    logic [3:0]    full;
    logic [1:0]    ptr;
    logic          slot_free;
    logic          gnt_found;
    logic [1:0]    gnt_idx;
    logic [1:0]    cand;

    // Ready depends only on held state, so producers never see out_ready combinationally.
    assign in_ready  = {4{rst_n}} & ~full;
    assign slot_free = ~out_valid | out_ready;

`ifdef TDM_STRICT_SLOT_EN
    always_comb begin
        cand      = ptr;
        gnt_idx   = ptr;
        gnt_found = full[ptr];
    end
`else
    // First full channel at or after ptr, wrapping.
    always_comb begin
        cand      = ptr;
        gnt_idx   = ptr;
        gnt_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!gnt_found && full[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full      <= 4'b0000;
            ptr       <= 2'b00;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'b00;
            for (int k = 0; k < 4; k++) begin
                buf_dat[k] <= '0;
            end
        end else begin
            // A channel is never captured and granted on the same edge.
            for (int k = 0; k < 4; k++) begin
                if (in_valid[k] && in_ready[k]) begin
                    buf_dat[k] <= in_data[k*DW +: DW];
                    full[k]    <= 1'b1;
                end
            end
            if (slot_free) begin
`ifdef TDM_STRICT_SLOT_EN
                ptr <= ptr + 2'd1;
                if (gnt_found) begin
                    out_data       <= buf_dat[gnt_idx];
                    out_sel        <= gnt_idx;
                    out_valid      <= 1'b1;
                    full[gnt_idx]  <= 1'b0;
                end else begin
                    out_data  <= '0;
                    out_sel   <= ptr;
                    out_valid <= 1'b0;
                end
`else
                if (gnt_found) begin
                    out_data       <= buf_dat[gnt_idx];
                    out_sel        <= gnt_idx;
                    out_valid      <= 1'b1;
                    full[gnt_idx]  <= 1'b0;
                    ptr            <= gnt_idx + 2'd1;
                end else begin
                    out_valid <= 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux_4_1.sv
// Directed vector bench for tdm_mux_4_1 (DW=8); expected values are hand-computed per vector.
module tb_tdm_mux_4_1;

    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            out_valid;
    logic            out_ready;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  iv;
        logic [31:0] din;
        logic        orr;
        logic [3:0]  e_rdy;
        logic        e_vld;
        logic [1:0]  e_sel;
        logic [7:0]  e_dat;
    } vec_t;

    vec_t vecs[$];

    tdm_mux_4_1 #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] e_rdy, input logic e_vld,
                         input logic [1:0] e_sel, input logic [7:0] e_dat);
        n_vec++;
        if (in_ready !== e_rdy || out_valid !== e_vld || out_sel !== e_sel || out_data !== e_dat) begin
            n_err++;
            $display("FAIL %s: got rdy=%b vld=%b sel=%0d dat=%h, want rdy=%b vld=%b sel=%0d dat=%h",
                     name, in_ready, out_valid, out_sel, out_data, e_rdy, e_vld, e_sel, e_dat);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst_n     = v.rst_n;
        in_valid  = v.iv;
        in_data   = v.din;
        out_ready = v.orr;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d", idx), v.e_rdy, v.e_vld, v.e_sel, v.e_dat);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_data   = '0;
        out_ready = 1'b1;

`ifdef TDM_STRICT_SLOT_EN
        // Fixed slots: only ch2 loaded, sel still walks 0..3.
        vecs.push_back('{1'b0, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b0100, 32'h00770000, 1'b1, 4'b1011, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1011, 1'b0, 2'd1, 8'h00});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b1, 2'd2, 8'h77});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b0, 2'd3, 8'h00});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b0, 2'd0, 8'h00});
`else
        // Reset held 3 clks with all valids high.
        vecs.push_back('{1'b0, 4'b1111, 32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b0, 4'b1111, 32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b0, 4'b1111, 32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b0, 2'd0, 8'h00});
        // Single channel 2.
        vecs.push_back('{1'b1, 4'b0100, 32'h00010000, 1'b1, 4'b1011, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b1, 2'd2, 8'h01});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b0, 2'd2, 8'h01});
        // Round robin from ptr=0 after a reset.
        vecs.push_back('{1'b0, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b0011, 1'b1, 2'd1, 8'hA1});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b0111, 1'b1, 2'd2, 8'hA2});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b1, 2'd3, 8'hA3});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b0, 2'd3, 8'hA3});
        // Backpressure on ch1: 5C held while 5D is captured behind it.
        vecs.push_back('{1'b1, 4'b0010, 32'h00005C00, 1'b0, 4'b1101, 1'b0, 2'd3, 8'hA3});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b0, 4'b1111, 1'b1, 2'd1, 8'h5C});
        vecs.push_back('{1'b1, 4'b0010, 32'h00005D00, 1'b0, 4'b1101, 1'b1, 2'd1, 8'h5C});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b0, 4'b1101, 1'b1, 2'd1, 8'h5C});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b0, 4'b1101, 1'b1, 2'd1, 8'h5C});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b1, 2'd1, 8'h5D});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b0, 2'd1, 8'h5D});
        // Reset with all four buffers full: nothing emerges afterwards.
        vecs.push_back('{1'b1, 4'b1111, 32'h44332211, 1'b0, 4'b0000, 1'b0, 2'd1, 8'h5D});
        vecs.push_back('{1'b0, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b0, 2'd0, 8'h00});
        // Skip empty channels: ch1, ch3, then ch0 captured during ch3 grant.
        vecs.push_back('{1'b1, 4'b1010, 32'hD300B100, 1'b1, 4'b0101, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b0111, 1'b1, 2'd1, 8'hB1});
        vecs.push_back('{1'b1, 4'b0001, 32'h000000C0, 1'b1, 4'b1110, 1'b1, 2'd3, 8'hD3});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b1, 2'd0, 8'hC0});
        vecs.push_back('{1'b1, 4'b0000, 32'h0,        1'b1, 4'b1111, 1'b0, 2'd0, 8'hC0});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Fairness: all channels refilled continuously, sel must cycle 0,1,2,3.
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        in_data  = 32'hF3F2F1F0;
        @(posedge clk);
        #1;
        check("fair_load", 4'b0000, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            logic [1:0] s;
            logic [3:0] r;
            s = 2'(i % 4);
            r = 4'b0001 << s;
            @(posedge clk);
            #1;
            check($sformatf("fair%0d", i), r, 1'b1, s, 8'hF0 + 8'(s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_mux_4_1.md
Name: tdm_mux_4_1

Overview:
- Sequential 4:1 time-division multiplexer. It is the gather end of the 1:4 demux path.
- Collects data from four independent valid/ready producer channels and serializes it onto one valid/ready output stream.
- Each output word is tagged with its 2-bit source select, so a downstream 1:4 demux can route it back out.
- Provides one-entry buffering per channel and round-robin arbitration.

Parameters:
- DW, 1, data width per channel in bits (DW >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_data  input  4*DW  channel k data on bits [k*DW +: DW]
- in_valid  input  4  per-channel valid
- in_ready  output  4  per-channel ready
- out_data  output  DW  serialized data
- out_sel  output  2  source channel index of out_data (2'b00..2'b11)
- out_valid  output  1  output word valid
- out_ready  input  1  downstream ready

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). All state updates on rising clk only.
- Reset (rst_n low at an edge):
  - full[3:0]=0, ptr=2'b00, out_valid=0, out_data=0, out_sel=2'b00.
  - in_ready=4'b0000 while rst_n is low.
  - Reset mid-operation discards all buffered and presented words; no partial output.
- Input stage, per channel k: holding register buf[k] plus flag full[k].
  - in_ready[k] = rst_n & ~full[k]. It is registered-state only, with no combinational path from out_ready.
  - Transfer occurs when in_valid[k] & in_ready[k] at an edge: buf[k]<=in_data slice, full[k]<=1.
- Output slot is free when (~out_valid | out_ready).
- Arbitration, on an edge with the slot free:
  - Search channels ptr, ptr+1, ptr+2, ptr+3 (mod 4) for the first full[g]=1.
  - Found: out_data<=buf[g], out_sel<=g, out_valid<=1, full[g]<=0, ptr<=g+1 (wraps 3->0).
  - None full: out_valid<=0; out_data and out_sel hold their values; ptr unchanged.
- Backpressure: while out_valid & ~out_ready, out_data, out_sel, out_valid and all full flags being held stay stable. Input capture into non-full buffers continues.
- Latency: a word accepted at edge N is present on the output at edge N+1 at the earliest, if it wins arbitration.
- Throughput:
  - Aggregate: up to 1 word per clk.
  - Per channel: at most 1 word per 2 clks, because a buffer freed at edge N reports in_ready=1 only after edge N.
- Simultaneous events:
  - Capture into channel j and a grant to channel g != j at the same edge are independent.
  - A channel cannot be captured and granted at the same edge, because capture requires full=0 and grant requires full=1.
- Fairness: with all four channels continuously full, out_sel cycles 0,1,2,3,0,... and no channel waits more than 3 grants.
- Ordering: per-channel order is preserved (depth 1). No words are dropped or duplicated.

Optional Feature:
- Macro: TDM_STRICT_SLOT_EN.
- Defined (fixed-slot TDM):
  - On every edge with the slot free, the block considers only channel ptr, and ptr<=ptr+1 unconditionally.
  - If full[ptr]: present it as normal.
  - Else: an idle slot with out_valid<=0, out_sel<=ptr, out_data<=0.
  - Resulting out_sel sequence is strictly 0,1,2,3 regardless of occupancy.
- Undefined: work-conserving round-robin, which skips empty channels as specified above.

Test Plan:
- Reset: hold rst_n=0 for 3 clks with in_valid=4'b1111 -> in_ready=0000, out_valid=0, out_sel=00, out_data=0. First edge after release -> in_ready=1111.
- Single channel (DW=1): in_valid=0100 with ch2 data 1 for one clk, out_ready=1 -> next edge out_valid=1, out_sel=10, out_data=1. Following edge -> out_valid=0.
- Round-robin: DW=8, load ch0..ch3 with 8'hA0, A1, A2, A3 in one clk, out_ready=1 -> four consecutive words in sel order 00,01,10,11, then out_valid=0.
- Backpressure: ch1=8'h5C presented, out_ready=0 for 4 clks -> out_data=5C and out_sel=01 are stable. Meanwhile in_ready[1]=1 accepts 8'h5D. Release -> 5C, then 5D with out_sel=01 on consecutive slots.
- Reset mid-stream: full=1111, assert rst_n=0 for 1 clk -> all full flags clear, out_valid=0. No buffered word appears after release.
- TDM_STRICT_SLOT_EN defined, only ch2 loaded, out_ready=1 -> out_sel 00,01,10,11 over 4 clks, with out_valid=1 only on the 10 slot.
